scratchmem_arb: RTL and testbench

SCRATCHMEM_ARB -- requirements
Module: scratchmem_arb

---
 rtl/fta_bus_pkg.sv | 11 +
 rtl/scratchmem_arb_pkg.sv | 38 +++
 rtl/rr_arb2.sv | 45 ++++
 rtl/scratchmem_arb.sv | 222 ++++++++++++++++++++++
 tb/tb_scratchmem_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fta_bus_pkg.sv
// Shared bus-level types and cycle-type encodings for the FTA request/response fabric.
package fta_bus_pkg;

  typedef logic [7:0] fta_tranid_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_FIXED   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_ERC     = 3'b011;

endpackage

// File: rtl/scratchmem_arb_pkg.sv
// Local types and helper functions for the two-requester scratch-memory arbiter.
package scratchmem_arb_pkg;
  import fta_bus_pkg::*;

  localparam int unsigned BEAT_SHIFT = 4;

  typedef struct packed {
    logic        we;
    logic [2:0]  cti;
    logic [5:0]  blen;
    logic [15:0] sel;
    logic [31:0] adr;
    logic [127:0] dat;
    fta_tranid_t tid;
    logic [3:0]  cid;
  } sreq_t;

  function automatic logic is_single(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_ERC);
  endfunction

  // Reads always come back with an ack; writes only when the requester asked for one.
  function automatic logic needs_ack(input logic we, input logic [2:0] cti);
    return (!we) || (cti == CTI_ERC);
  endfunction

  function automatic logic credit_ok(input logic [6:0] cnt, input logic [5:0] blen,
                                     input logic single, input logic [6:0] max_out);
    logic [7:0] need;
    if (single) begin
      need = {1'b0, cnt} + 8'd1;
    end else begin
      need = {1'b0, cnt} + {2'b00, blen} + 8'd1;
    end
    return need <= {1'b0, max_out};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the winner of a committed grant hands priority to the other side.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic prio_q, prio_d;

  // Grant selection: priority holder wins a tie, a lone requester always wins.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!prio_q || !req_i[1])) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end else begin
      gnt_o = 2'b00;
    end
  end

  // Priority rotation after a committed grant.
  always_comb begin
    prio_d = prio_q;
    if (advance_i && gnt_o[0]) begin
      prio_d = 1'b1;
    end else if (advance_i && gnt_o[1]) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/scratchmem_arb.sv
// Two-requester arbiter in front of a scratch memory: credit-limited round-robin
// beat/burst issue on the request side and cid-based routing on the response side.
module scratchmem_arb
  import fta_bus_pkg::*;
  import scratchmem_arb_pkg::*;
#(
  parameter logic [6:0] MAX_OUT  = 7'd64,
  parameter logic [3:0] CID_BASE = 4'd2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          m_cyc_i,
  input  logic [1:0]          m_stb_i,
  input  logic [1:0]          m_we_i,
  input  logic [1:0][2:0]     m_cti_i,
  input  logic [1:0][5:0]     m_blen_i,
  input  logic [1:0][15:0]    m_sel_i,
  input  logic [1:0][31:0]    m_adr_i,
  input  logic [1:0][127:0]   m_dat_i,
  input  fta_tranid_t [1:0]   m_tid_i,
  output logic [1:0]          m_next_o,
  output logic [1:0]          m_ack_o,
  output logic [1:0][127:0]   m_dat_o,
  output fta_tranid_t [1:0]   m_tid_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [2:0]          s_cti_o,
  output logic [5:0]          s_blen_o,
  output logic [15:0]         s_sel_o,
  output logic [31:0]         s_adr_o,
  output logic [127:0]        s_dat_o,
  output fta_tranid_t         s_tid_o,
  output logic [3:0]          s_cid_o,
  input  logic                s_ack_i,
  input  logic [127:0]        s_dat_i,
  input  fta_tranid_t         s_tid_i,
  input  logic [3:0]          s_cid_i
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [5:0]        beat_q, beat_d;
  logic [5:0]        blen_q, blen_d;
  logic [31:0]       base_q, base_d;
  logic [1:0][6:0]   cnt_q, cnt_d;
  logic              s_vld_q;
  sreq_t             s_req_q, s_req_d;
  logic [1:0]        m_ack_q;
  logic [1:0][127:0] m_dat_q;
  fta_tranid_t [1:0] m_tid_q;

  logic [1:0]        elig_s;
  logic [1:0]        gnt_s;
  logic [1:0]        accept_s;
  logic [1:0]        inc_s;
  logic [1:0]        dec_s;
  logic              sel_s;
  logic [31:0]       issue_adr_s;
  logic              ack_hit_s;

  // Per-requester eligibility: a live request whose whole transfer fits the credit window.
  always_comb begin
    elig_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig_s[i] = m_cyc_i[i] & m_stb_i[i] &
                  credit_ok(cnt_q[i], m_blen_i[i], is_single(m_cti_i[i]), MAX_OUT);
    end
  end

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (elig_s & {2{state_q == IDLE}}),
    .advance_i (state_q == IDLE),
    .gnt_o     (gnt_s)
  );

  // Issue FSM: one beat per cycle in IDLE, then the held grant streams the rest of a burst.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    beat_d      = beat_q;
    blen_d      = blen_q;
    base_d      = base_q;
    accept_s    = 2'b00;
    sel_s       = 1'b0;
    issue_adr_s = 32'd0;
    case (state_q)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          sel_s       = gnt_s[1];
          accept_s    = gnt_s;
          issue_adr_s = m_adr_i[gnt_s[1]];
          if (!is_single(m_cti_i[gnt_s[1]]) && (m_blen_i[gnt_s[1]] != 6'd0)) begin
            state_d = BURST;
            owner_d = gnt_s[1];
            beat_d  = 6'd1;
            blen_d  = m_blen_i[gnt_s[1]];
            base_d  = m_adr_i[gnt_s[1]];
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        sel_s = owner_q;
        if (!m_cyc_i[owner_q]) begin
          state_d = IDLE;
        end else begin
          accept_s    = owner_q ? 2'b10 : 2'b01;
          issue_adr_s = base_q + {22'd0, beat_q, 4'd0};
          if (beat_q == blen_q) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next request word presented to memory the cycle after acceptance.
  always_comb begin
    s_req_d = '0;
    if (|accept_s) begin
      s_req_d.we   = m_we_i[sel_s];
      s_req_d.cti  = m_cti_i[sel_s];
      s_req_d.blen = m_blen_i[sel_s];
      s_req_d.sel  = m_sel_i[sel_s];
      s_req_d.adr  = issue_adr_s;
      s_req_d.dat  = m_dat_i[sel_s];
      s_req_d.tid  = m_tid_i[sel_s];
      s_req_d.cid  = {CID_BASE[3:1], sel_s};
    end else begin
      s_req_d = '0;
    end
  end

  // Outstanding-ack bookkeeping; a stray ack on an empty counter leaves it at zero.
  always_comb begin
    ack_hit_s = s_ack_i && (s_cid_i[3:1] == CID_BASE[3:1]);
    dec_s     = ack_hit_s ? (s_cid_i[0] ? 2'b10 : 2'b01) : 2'b00;
    inc_s     = 2'b00;
    cnt_d     = cnt_q;
    for (int i = 0; i < 2; i++) begin
      inc_s[i] = accept_s[i] & needs_ack(m_we_i[i], m_cti_i[i]);
      if (inc_s[i] && !dec_s[i]) begin
        cnt_d[i] = cnt_q[i] + 7'd1;
      end else if (!inc_s[i] && dec_s[i] && (cnt_q[i] != 7'd0)) begin
        cnt_d[i] = cnt_q[i] - 7'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Control state and credit counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      beat_q  <= 6'd0;
      blen_q  <= 6'd0;
      base_q  <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      blen_q  <= blen_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered request and response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_vld_q <= 1'b0;
      s_req_q <= '0;
      m_ack_q <= 2'b00;
      m_dat_q <= '0;
      m_tid_q <= '0;
    end else begin
      s_vld_q <= |accept_s;
      s_req_q <= s_req_d;
      m_ack_q <= dec_s;
      for (int i = 0; i < 2; i++) begin
        m_dat_q[i] <= dec_s[i] ? s_dat_i : 128'd0;
        m_tid_q[i] <= dec_s[i] ? s_tid_i : fta_tranid_t'(8'd0);
      end
    end
  end

  // The accept pulse is combinational, so it is forced low while reset is asserted.
  assign m_next_o = accept_s & {2{rst_ni}};
  assign m_ack_o  = m_ack_q;
  assign m_dat_o  = m_dat_q;
  assign m_tid_o  = m_tid_q;
  assign s_cyc_o  = s_vld_q;
  assign s_stb_o  = s_vld_q;
  assign s_we_o   = s_req_q.we;
  assign s_cti_o  = s_req_q.cti;
  assign s_blen_o = s_req_q.blen;
  assign s_sel_o  = s_req_q.sel;
  assign s_adr_o  = s_req_q.adr;
  assign s_dat_o  = s_req_q.dat;
  assign s_tid_o  = s_req_q.tid;
  assign s_cid_o  = s_req_q.cid;

endmodule

// File: tb/tb_scratchmem_arb.sv
// Bench for scratchmem_arb: two instances (MAX_OUT 64 and 4) share stimulus and are
// compared every cycle against a transaction-level reference model.
module tb_scratchmem_arb;
  import fta_bus_pkg::*;

  localparam logic [2:0] CID_HI = 3'b001;  // CID_BASE = 4'd2 -> bits [3:1]

  logic clk, rst_n;
  logic [1:0]          m_cyc, m_stb, m_we;
  logic [1:0][2:0]     m_cti;
  logic [1:0][5:0]     m_blen;
  logic [1:0][15:0]    m_sel;
  logic [1:0][31:0]    m_adr;
  logic [1:0][127:0]   m_dat;
  fta_tranid_t [1:0]   m_tid;
  logic                s_ack;
  logic [127:0]        s_dat;
  fta_tranid_t         s_tid;
  logic [3:0]          s_cid;

  logic [1:0]          o_next [2];
  logic [1:0]          o_ack  [2];
  logic [1:0][127:0]   o_mdat [2];
  fta_tranid_t [1:0]   o_mtid [2];
  logic                o_scyc [2];
  logic                o_sstb [2];
  logic                o_swe  [2];
  logic [2:0]          o_scti [2];
  logic [5:0]          o_sblen[2];
  logic [15:0]         o_ssel [2];
  logic [31:0]         o_sadr [2];
  logic [127:0]        o_sdat [2];
  fta_tranid_t         o_stid [2];
  logic [3:0]          o_scid [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam logic [6:0] MO = (g == 0) ? 7'd64 : 7'd4;
    scratchmem_arb #(.MAX_OUT(MO), .CID_BASE(4'd2)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_cti_i(m_cti),
      .m_blen_i(m_blen), .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_tid_i(m_tid),
      .m_next_o(o_next[g]), .m_ack_o(o_ack[g]), .m_dat_o(o_mdat[g]), .m_tid_o(o_mtid[g]),
      .s_cyc_o(o_scyc[g]), .s_stb_o(o_sstb[g]), .s_we_o(o_swe[g]), .s_cti_o(o_scti[g]),
      .s_blen_o(o_sblen[g]), .s_sel_o(o_ssel[g]), .s_adr_o(o_sadr[g]), .s_dat_o(o_sdat[g]),
      .s_tid_o(o_stid[g]), .s_cid_o(o_scid[g]),
      .s_ack_i(s_ack), .s_dat_i(s_dat), .s_tid_i(s_tid), .s_cid_i(s_cid)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model state, one copy per instance.
  int          mdl_cnt [2][2];
  int          mdl_prio[2];
  bit          mdl_inb [2];
  int          mdl_own [2];
  int          mdl_left[2];
  logic [31:0] mdl_nadr[2];

  logic [1:0]        x_next [2];
  logic [1:0]        x_ack  [2];
  logic [1:0][127:0] x_mdat [2];
  fta_tranid_t [1:0] x_mtid [2];
  logic              x_scyc [2];
  logic              x_swe  [2];
  logic [2:0]        x_scti [2];
  logic [5:0]        x_sblen[2];
  logic [15:0]       x_ssel [2];
  logic [31:0]       x_sadr [2];
  logic [127:0]      x_sdat [2];
  fta_tranid_t       x_stid [2];
  logic [3:0]        x_scid [2];

  logic [1:0] seen_next_a, seen_next_b;

  function automatic bit single_beat(input logic [2:0] c);
    return (c == CTI_CLASSIC) || (c == CTI_ERC);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mdl_cnt[k][0] = 0; mdl_cnt[k][1] = 0;
      mdl_prio[k] = 0; mdl_inb[k] = 1'b0; mdl_own[k] = 0; mdl_left[k] = 0; mdl_nadr[k] = 32'd0;
    end
  endtask

  // One cycle of the transaction-level model for instance k, from the current inputs.
  task automatic model_step(input int k);
    int a, lim, need;
    logic [31:0] adr;
    logic [1:0] el, dec;
    bit inc;
    lim = (k == 0) ? 64 : 4;
    a = -1; adr = 32'd0; el = 2'b00;
    if (!mdl_inb[k]) begin
      for (int i = 0; i < 2; i++) begin
        need = single_beat(m_cti[i]) ? 1 : int'(m_blen[i]) + 1;
        el[i] = m_cyc[i] && m_stb[i] && (mdl_cnt[k][i] + need <= lim);
      end
      if (el == 2'b11) a = mdl_prio[k];
      else if (el[0]) a = 0;
      else if (el[1]) a = 1;
      if (a >= 0) begin
        mdl_prio[k] = 1 - a;
        adr = m_adr[a];
        if (!single_beat(m_cti[a]) && m_blen[a] != 6'd0) begin
          mdl_inb[k] = 1'b1; mdl_own[k] = a; mdl_left[k] = int'(m_blen[a]);
          mdl_nadr[k] = m_adr[a] + 32'd16;
        end
      end
    end else if (!m_cyc[mdl_own[k]]) begin
      mdl_inb[k] = 1'b0;
    end else begin
      a = mdl_own[k];
      adr = mdl_nadr[k];
      mdl_nadr[k] = mdl_nadr[k] + 32'd16;
      mdl_left[k]--;
      if (mdl_left[k] == 0) mdl_inb[k] = 1'b0;
    end
    x_next[k] = (a == 0) ? 2'b01 : (a == 1) ? 2'b10 : 2'b00;
    x_scyc[k] = (a >= 0);
    x_swe[k] = 1'b0; x_scti[k] = 3'd0; x_sblen[k] = 6'd0; x_ssel[k] = 16'd0;
    x_sadr[k] = 32'd0; x_sdat[k] = 128'd0; x_stid[k] = 8'd0; x_scid[k] = 4'd0;
    if (a >= 0) begin
      x_swe[k] = m_we[a]; x_scti[k] = m_cti[a]; x_sblen[k] = m_blen[a]; x_ssel[k] = m_sel[a];
      x_sadr[k] = adr; x_sdat[k] = m_dat[a]; x_stid[k] = m_tid[a]; x_scid[k] = {CID_HI, a[0]};
    end
    dec = (s_ack && s_cid[3:1] == CID_HI) ? (s_cid[0] ? 2'b10 : 2'b01) : 2'b00;
    for (int i = 0; i < 2; i++) begin
      inc = (a == i) && (!m_we[i] || m_cti[i] == CTI_ERC);
      if (inc && !dec[i]) mdl_cnt[k][i]++;
      else if (!inc && dec[i] && mdl_cnt[k][i] > 0) mdl_cnt[k][i]--;
      x_mdat[k][i] = dec[i] ? s_dat : 128'd0;
      x_mtid[k][i] = dec[i] ? s_tid : 8'd0;
    end
    x_ack[k] = dec;
  endtask

  task automatic check_regs(input int k);
    check($sformatf("s_cyc%0d", k),  128'(o_scyc[k]),  128'(x_scyc[k]));
    check($sformatf("s_stb%0d", k),  128'(o_sstb[k]),  128'(x_scyc[k]));
    check($sformatf("s_we%0d", k),   128'(o_swe[k]),   128'(x_swe[k]));
    check($sformatf("s_cti%0d", k),  128'(o_scti[k]),  128'(x_scti[k]));
    check($sformatf("s_blen%0d", k), 128'(o_sblen[k]), 128'(x_sblen[k]));
    check($sformatf("s_sel%0d", k),  128'(o_ssel[k]),  128'(x_ssel[k]));
    check($sformatf("s_adr%0d", k),  128'(o_sadr[k]),  128'(x_sadr[k]));
    check($sformatf("s_dat%0d", k),  o_sdat[k],        x_sdat[k]);
    check($sformatf("s_tid%0d", k),  128'(o_stid[k]),  128'(x_stid[k]));
    check($sformatf("s_cid%0d", k),  128'(o_scid[k]),  128'(x_scid[k]));
    check($sformatf("m_ack%0d", k),  128'(o_ack[k]),   128'(x_ack[k]));
    check($sformatf("m_dat0_%0d", k), o_mdat[k][0],    x_mdat[k][0]);
    check($sformatf("m_dat1_%0d", k), o_mdat[k][1],    x_mdat[k][1]);
    check($sformatf("m_tid%0d", k),  128'(o_mtid[k]),  128'(x_mtid[k]));
  endtask

  task automatic check_zero(input int k);
    check($sformatf("rst_next%0d", k), 128'(o_next[k]), 128'd0);
    check($sformatf("rst_ack%0d", k),  128'(o_ack[k]),  128'd0);
    check($sformatf("rst_mdat%0d", k), 128'(o_mdat[k][0] | o_mdat[k][1]), 128'd0);
    check($sformatf("rst_mtid%0d", k), 128'(o_mtid[k]), 128'd0);
    check($sformatf("rst_scyc%0d", k), 128'({o_scyc[k], o_sstb[k], o_swe[k]}), 128'd0);
    check($sformatf("rst_sreq%0d", k), 128'({o_scti[k], o_sblen[k], o_ssel[k], o_stid[k], o_scid[k]}), 128'd0);
    check($sformatf("rst_sadr%0d", k), 128'(o_sadr[k]), 128'd0);
    check($sformatf("rst_sdat%0d", k), o_sdat[k], 128'd0);
  endtask

  // One clock: accept pulses checked mid-cycle, registered outputs just after the edge.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      check($sformatf("next%0d", k), 128'(o_next[k]), 128'(x_next[k]));
    end
    seen_next_a = o_next[0];
    seen_next_b = o_next[1];
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_regs(k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) check_zero(k);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input bit cyc, input bit we, input logic [2:0] cti,
                         input logic [5:0] blen, input logic [31:0] adr);
    m_cyc[i] = cyc; m_stb[i] = cyc; m_we[i] = we; m_cti[i] = cti; m_blen[i] = blen;
    m_adr[i] = adr; m_sel[i] = 16'(($urandom() & 32'hFFFF) | 32'h1);
    m_dat[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    m_tid[i] = fta_tranid_t'($urandom());
  endtask

  task automatic set_ack(input bit v, input logic [3:0] cid);
    s_ack = v; s_cid = cid;
    s_dat = {$urandom(), $urandom(), $urandom(), $urandom()};
    s_tid = fta_tranid_t'($urandom());
  endtask

  task automatic clear_inputs();
    set_req(0, 1'b0, 1'b0, CTI_CLASSIC, 6'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, CTI_CLASSIC, 6'd0, 32'd0);
    set_ack(1'b0, 4'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int beats;
    logic [3:0] cids [7];
    logic [2:0] ctis [4];
    cids = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hF, 4'h4, 4'h0};
    ctis = '{CTI_CLASSIC, CTI_ERC, CTI_INCR, CTI_FIXED};
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #3;
    do_reset();

    // Alternating single reads, then cid-routed acks.
    set_req(0, 1'b1, 1'b0, CTI_CLASSIC, 6'd0, 32'h0000_0040);
    set_req(1, 1'b1, 1'b0, CTI_CLASSIC, 6'd0, 32'h0000_0080);
    for (int j = 0; j < 4; j++) begin
      step();
      check("rr_alternate", 128'(seen_next_a), (j % 2 == 0) ? 128'd1 : 128'd2);
    end
    clear_inputs();
    set_ack(1'b1, 4'h2);
    step();
    check("ack_route0", 128'(o_ack[0]), 128'd1);
    set_ack(1'b1, 4'h3);
    step();
    check("ack_route1", 128'(o_ack[0]), 128'd2);
    set_ack(1'b0, 4'h0);

    // blen=3 incrementing burst from requester 0 against a competing single read.
    do_reset();
    set_req(0, 1'b1, 1'b0, CTI_INCR, 6'd3, 32'h0000_0100);
    set_req(1, 1'b1, 1'b0, CTI_CLASSIC, 6'd0, 32'h0000_2000);
    for (int j = 0; j < 5; j++) begin
      step();
      if (j < 4) begin
        check("burst_adr", 128'(o_sadr[0]), 128'(32'h100 + 32'(16 * j)));
        check("burst_hold", 128'(seen_next_a), 128'd1);
      end else begin
        check("burst_then_other", 128'(seen_next_a), 128'd2);
      end
    end

    // Credit limit on the MAX_OUT=4 instance with acks withheld.
    do_reset();
    clear_inputs();
    set_req(0, 1'b1, 1'b0, CTI_CLASSIC, 6'd0, 32'h0000_0200);
    for (int j = 0; j < 5; j++) begin
      step();
      check("credit_fill", 128'(seen_next_b), (j < 4) ? 128'd1 : 128'd0);
    end
    set_ack(1'b1, 4'h2);
    step();
    check("credit_ack_cycle", 128'(seen_next_b), 128'd0);
    set_ack(1'b0, 4'h0);
    step();
    check("credit_released", 128'(seen_next_b), 128'd1);

    // Ack and issue in the same cycle leave the count unchanged; foreign cid is dropped.
    do_reset();
    clear_inputs();
    set_req(0, 1'b1, 1'b0, CTI_CLASSIC, 6'd0, 32'h0000_0300);
    repeat (3) step();
    set_ack(1'b1, 4'h2);
    step();
    check("both_cycle_issue", 128'(seen_next_b), 128'd1);
    set_ack(1'b0, 4'h0);
    step();
    check("both_cycle_fourth", 128'(seen_next_b), 128'd1);
    step();
    check("both_cycle_full", 128'(seen_next_b), 128'd0);
    clear_inputs();
    set_ack(1'b1, 4'hF);
    step();
    check("foreign_ack", 128'(o_ack[0]), 128'd0);
    set_ack(1'b0, 4'h0);

    // Requester 1 abandons a blen=7 burst after two beats.
    do_reset();
    clear_inputs();
    beats = 0;
    set_req(1, 1'b1, 1'b1, CTI_INCR, 6'd7, 32'h0000_4000);
    step(); beats += int'(o_scyc[0]);
    step(); beats += int'(o_scyc[0]);
    check("drop_beat2_adr", 128'(o_sadr[0]), 128'h4010);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, CTI_CLASSIC, 6'd0, 32'h0000_0500);
    step(); beats += int'(o_scyc[0]);
    check("drop_no_grant", 128'(seen_next_a), 128'd0);
    check("drop_beats", 128'(beats), 128'd2);
    step();
    check("drop_back_idle", 128'(seen_next_a), 128'd1);

    // Reset in the middle of a burst; requester 0 wins first afterwards.
    do_reset();
    set_req(0, 1'b1, 1'b0, CTI_INCR, 6'd3, 32'h0000_0800);
    set_req(1, 1'b1, 1'b0, CTI_CLASSIC, 6'd0, 32'h0000_0900);
    step();
    step();
    do_reset();
    set_req(0, 1'b1, 1'b0, CTI_CLASSIC, 6'd0, 32'h0000_0A00);
    step();
    check("post_reset_grant", 128'(seen_next_a), 128'd1);
    clear_inputs();
    set_ack(1'b1, 4'h3);
    step();
    set_ack(1'b0, 4'h0);

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        set_req(i, ($urandom_range(0, 5) != 0), $urandom_range(0, 1) == 1,
                ctis[$urandom_range(0, 3)], 6'($urandom_range(0, 5)),
                {$urandom(), 4'h0} & 32'hFFFF_FFF0);
        m_stb[i] = m_cyc[i] && ($urandom_range(0, 3) != 0);
      end
      set_ack($urandom_range(0, 2) == 0, cids[$urandom_range(0, 6)]);
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
